// File: rtl/k12a_pkg.sv
// Shared definitions for the K12a multi-cycle ALU: opcodes, FSM states,
// operand-select encoding and the registered flag bundle.
package k12a_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0,
        OP_AND    = 4'h1,
        OP_OR     = 4'h2,
        OP_XOR    = 4'h3,
        OP_ADD    = 4'h4,
        OP_ADD_B  = 4'h5,
        OP_SAR1   = 4'h6,
        OP_PASS_B = 4'h7,
        OP_MUL_LO = 4'h8,
        OP_MUL_HI = 4'h9,
        OP_SHL    = 4'hA,
        OP_SHR    = 4'hB,
        OP_SAR    = 4'hC,
        OP_ROL    = 4'hD,
        OP_RSV_E  = 4'hE,
        OP_RSV_F  = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } alu_state_t;

    typedef enum logic {
        ALU_OPERAND_B    = 1'b0,
        ALU_OPERAND_INST = 1'b1
    } alu_operand_sel_t;

    // Field order makes bit i of the packed vector the flag chosen by cond_sel == i.
    typedef struct packed {
        logic sle;
        logic slt;
        logic ule;
        logic ult;
        logic overflow;
        logic lsb;
        logic negative;
        logic zero;
    } alu_flags_t;

    function automatic logic is_mul(input alu_op_t op);
        return (op == OP_MUL_LO) || (op == OP_MUL_HI);
    endfunction

endpackage

// File: rtl/k12a_alu_flags.sv
// Flag derivation from the adder outputs and the final result.
// Latency: combinational. Backpressure: none.
// Multiply replaces the adder overflow with "high half non-zero".
module k12a_alu_flags
    import k12a_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             carry_out,
    input  logic             a_msb,
    input  logic             op2_msb,
    input  logic [WIDTH-1:0] result,
    input  logic             mul_op,
    input  logic             mul_hi_nz,
    output alu_flags_t       flags
);

    logic add_ovf;
    logic add_zero;
    logic ult;
    logic slt;

    always_comb begin
        add_ovf  = (a_msb == op2_msb) && (sum[WIDTH-1] != a_msb);
        add_zero = ~|sum;
        ult      = ~carry_out;
        slt      = sum[WIDTH-1] ^ add_ovf;

        flags          = '0;
        flags.zero     = ~|result;
        flags.negative = result[WIDTH-1];
        flags.lsb      = result[0];
        flags.overflow = mul_op ? mul_hi_nz : add_ovf;
        flags.ult      = ult;
        flags.ule      = ult | add_zero;
        flags.slt      = slt;
        flags.sle      = slt | add_zero;
    end

endmodule

// File: rtl/k12a_alu_mc.sv
// Multi-cycle K12a ALU: logic/add single-cycle, shift-add multiply, bitwise shifts.
// Latency: done at N+1 (single), N+WIDTH+1 (mul), N+k+1 (shift by k).
// Backpressure: start only accepted while idle; starts during busy are dropped.
module k12a_alu_mc
    import k12a_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             alu_subtract,
    input  logic             alu_operand_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [2:0]       cond_sel,
    input  logic             alu_load,
    inout  wire  [WIDTH-1:0] data_bus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_condition
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

    alu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   a_q, op2_q;
    logic               sub_q;
    alu_op_t            op_q;
    alu_flags_t         flags_q, flags_n;

    alu_op_t          op_in;
    logic [WIDTH-1:0] op2_in;
    logic             in_idle;
    logic             complete;
    logic [CNT_W-1:0] iter;
    logic [CNT_W-1:0] sat_k;
    logic [CNT_W-1:0] rot_k;

    assign op_in   = alu_op_t'(op);
    assign op2_in  = (alu_operand_sel == ALU_OPERAND_INST) ? imm : b;
    assign in_idle = (state_q == ST_IDLE);

    // Iteration count; zero means the op completes straight from IDLE.
    always_comb begin
        sat_k = (op2_in > W_VAL) ? W_CNT : CNT_W'(op2_in);
        rot_k = CNT_W'(op2_in % W_VAL);
        case (op_in)
            OP_MUL_LO, OP_MUL_HI:   iter = W_CNT;
            OP_SHL, OP_SHR, OP_SAR: iter = sat_k;
            OP_ROL:                 iter = rot_k;
            default:                iter = '0;
        endcase
    end

    // Adder sees live operands on the accept edge, latched ones at the end of RUN.
    logic [WIDTH-1:0] add_a, add_op2, op2_eff;
    logic             add_sub;
    logic [WIDTH:0]   add_full;

    always_comb begin
        add_a    = in_idle ? a            : a_q;
        add_op2  = in_idle ? op2_in       : op2_q;
        add_sub  = in_idle ? alu_subtract : sub_q;
        op2_eff  = add_sub ? ~add_op2 : add_op2;
        add_full = {1'b0, add_a} + {1'b0, op2_eff} + (WIDTH + 1)'(add_sub);
    end

    logic [WIDTH-1:0] single_result;

    always_comb begin
        case (op_in)
            OP_AND:            single_result = a & op2_in;
            OP_OR:             single_result = a | op2_in;
            OP_XOR:            single_result = a ^ op2_in;
            OP_ADD, OP_ADD_B:  single_result = add_full[WIDTH-1:0];
            OP_SAR1:           single_result = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_PASS_B:         single_result = op2_in;
            default:           single_result = a;
        endcase
    end

    // One iteration of the multi-cycle datapath. Shifts live in the low half.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   lo;

    always_comb begin
        lo      = prod_q[WIDTH-1:0];
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : '0)};
        case (op_q)
            OP_MUL_LO, OP_MUL_HI: prod_step = {mul_sum, lo[WIDTH-1:1]};
            OP_SHL:  prod_step = {prod_q[2*WIDTH-1:WIDTH], lo[WIDTH-2:0], 1'b0};
            OP_SHR:  prod_step = {prod_q[2*WIDTH-1:WIDTH], 1'b0, lo[WIDTH-1:1]};
            OP_SAR:  prod_step = {prod_q[2*WIDTH-1:WIDTH], lo[WIDTH-1], lo[WIDTH-1:1]};
            OP_ROL:  prod_step = {prod_q[2*WIDTH-1:WIDTH], lo[WIDTH-2:0], lo[WIDTH-1]};
            default: prod_step = prod_q;
        endcase
    end

    logic [WIDTH-1:0] fin_result;
    logic             run_mul;

    assign run_mul = (state_q == ST_RUN) && is_mul(op_q);

    always_comb begin
        if (in_idle)
            fin_result = single_result;
        else if (op_q == OP_MUL_HI)
            fin_result = prod_step[2*WIDTH-1:WIDTH];
        else
            fin_result = prod_step[WIDTH-1:0];
    end

    k12a_alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .sum       (add_full[WIDTH-1:0]),
        .carry_out (add_full[WIDTH]),
        .a_msb     (add_a[WIDTH-1]),
        .op2_msb   (op2_eff[WIDTH-1]),
        .result    (fin_result),
        .mul_op    (run_mul),
        .mul_hi_nz (|prod_step[2*WIDTH-1:WIDTH]),
        .flags     (flags_n)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (iter != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = iter;
                        prod_d  = is_mul(op_in) ? {{WIDTH{1'b0}}, op2_in}
                                                : {{WIDTH{1'b0}}, a};
                    end else begin
                        state_d  = ST_FIN;
                        complete = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d  = cnt_q - 1'b1;
                prod_d = prod_step;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_FIN;
                    complete = 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            a_q     <= '0;
            op2_q   <= '0;
            sub_q   <= 1'b0;
            op_q    <= OP_PASS_A;
            result  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            if (in_idle && start) begin
                a_q   <= a;
                op2_q <= op2_in;
                sub_q <= alu_subtract;
                op_q  <= op_in;
            end
            if (complete) begin
                result  <= fin_result;
                flags_q <= flags_n;
            end
        end
    end

    logic [7:0] flag_vec;

    assign flag_vec      = flags_q;
    assign alu_condition = flag_vec[cond_sel];
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign data_bus      = alu_load ? result : {WIDTH{1'bz}};

endmodule

// File: doc/k12a_alu_mc.md
# k12a_alu_mc

Multi-cycle, width-parametrised successor to the K12a single-cycle ALU. Keeps the eight single-cycle operations and the eight-way condition select, and adds sequential unsigned multiply and variable-amount shifts/rotate behind a start/busy/done handshake. Results and flags are registered. The block sits between the register file (a, b) and the instruction register (imm), and drives the shared data bus under `alu_load`.

## Interface
- `WIDTH`, default 8: datapath width in bits; must be ≥ 4. Derived localparam `CNT_W` = clog2(WIDTH+1).
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only on an edge where `busy`=0.
- `op`  in  4  `alu_op_t`, sampled at accept.
- `alu_subtract`  in  1  sampled at accept; selects a − op2 in the adder.
- `alu_operand_sel`  in  `alu_operand_sel_t`  op2 source: B or INST (imm); sampled at accept.
- `a`, `b`, `imm`  in  WIDTH each  operands, sampled at accept.
- `cond_sel`  in  3  condition select.
- `alu_load`  in  1  drive `data_bus`.
- `data_bus`  inout  WIDTH  carries `result` when `alu_load`=1, else high-Z.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  registered result.
- `alu_condition`  out  1  selected registered flag.

## Operation
- Ops 0–7 (single-cycle): 0 pass a; 1 AND; 2 OR; 3 XOR; 4 and 5 adder (a + op2, or a + ~op2 + 1 when subtract); 6 arithmetic shift right by 1; 7 pass op2.
- Ops 8–9: unsigned WIDTH×WIDTH shift-add multiply, one partial product per cycle, WIDTH iterations. Op 8 returns the low half, op 9 the high half.
- Ops A–D: shift a by k, one bit per cycle. A = SHL, B = SHR logical, C = SAR, D = ROL.
  - For A–C, k = min(op2, WIDTH).
  - For D, k = op2 mod WIDTH.
  - k = 0 completes as a single-cycle op with result a.
- Ops E–F are reserved: they complete as single-cycle ops with result a, and flags update normally.
- FSM states are IDLE, RUN, and FIN.
  - IDLE + accepted start → FIN for single-cycle ops and for k = 0; otherwise → RUN with counter = iterations.
  - RUN decrements the counter each cycle and goes → FIN when the counter reaches 1 on that edge.
  - FIN → IDLE unconditionally.
- `result`, the flags, and `done` update on the edge entering FIN.
- Flags are registered and updated only at completion:
  - zero, negative, lsb are taken from the final result.
  - overflow, ult, ule, slt, sle are taken from the adder evaluated on the latched a/op2/subtract:
    - ult = ~carry_out
    - ule = ult | adder_zero
    - slt = adder_msb ^ overflow
    - sle = slt | adder_zero
  - Exception for ops 8–9: overflow = (high half ≠ 0).
- `alu_condition` is a combinational mux of the registered flags: 0 zero, 1 negative, 2 lsb, 3 overflow, 4 ult, 5 ule, 6 slt, 7 sle.

## Timing
- Reset value of every output:
  - state IDLE, `busy`=0, `done`=0.
  - `result`=0 and all flags=0, so `alu_condition`=0.
  - counter=0, product accumulator=0.
  - `data_bus` follows `alu_load`.
- Latency with start accepted at edge N:
  - single-cycle ops: `done` high in cycle N+1.
  - multiply: `done` in cycle N+WIDTH+1.
  - shifts: `done` in cycle N+k+1.
- `busy`=1 from cycle N+1 through the cycle in which `done`=1, inclusive. `done` is high for exactly one cycle.
- `result` holds its value until the next completion. While busy it shows the previous result, and `alu_load` drives that value.
- `start` while `busy`=1 is ignored; it is neither queued nor does it disturb the operation.
- `start` in the FIN cycle is ignored. Back-to-back throughput is therefore one op per 2 cycles.
- Reset mid-RUN or during FIN aborts the operation: on the next cycle the block shows the reset values and no `done` pulse occurs.
- Operand inputs may change freely after the accept edge.

## Structure
- `k12a_pkg` holds the shared definitions: `alu_op_t` (4-bit enum, values 0–F as above), `alu_state_t` (IDLE/RUN/FIN), and the existing `alu_operand_sel_t`.
- Sub-module `k12a_alu_flags`, parametrised by WIDTH, contains the combinational flag derivation from the adder's carry_out, sum, and input MSBs plus the result. It is instantiated once.
- The top level contains the FSM, counter, the 2·WIDTH product/shift register, and the tristate driver.

## Test plan
1. **Add with overflow.** WIDTH=8, op 4, a=0x7F, imm=0x01 (INST), subtract=0 → `done` at N+1, result=0x80, negative=1, overflow=1, zero=0.
2. **Subtract / compare.** Op 5, a=0x05, b=0x07, subtract=1 → result=0xFE, ult=1, ule=1, slt=1, zero=0. Then cond_sel sweep 0..7 matches the flags.
3. **Multiply.** Op 8, a=0x12, b=0x34 → `done` exactly at N+9, result=0xA8, overflow=1. Op 9, same operands → result=0x03.
4. **Shifts.**
   - Op C, a=0x90, k=3 → result=0xF2 at N+4.
   - Op A, k=9 → result=0x00 at N+9 (saturated to 8).
   - Op D, a=0x81, k=9 → result=0x03 at N+2.
   - k=0 → result=a at N+1.
5. **Handshake / reset.**
   - Start pulses during RUN and FIN are ignored; the running multiply still finishes at N+9 with the original operands.
   - `reset` asserted in RUN cycle 3 → next cycle busy=0, done=0, result=0x00, and no late `done` follows.
6. **Bus and width.**
   - alu_load=1 → data_bus=result; alu_load=0 → data_bus high-Z.
   - WIDTH=16, op 9, a=b=0x0100 → result=0x0001 at N+17.
